// File: rtl/bhr_index_gen_if.sv
// Fetch/resolve bundle for the branch history index generator.
// The master drives fetch and resolve inputs; the slave is the generator.
interface bhr_index_gen_if;
  logic [31:0] pc;
  logic        fetch_br;
  logic        predict;
  logic        res_valid;
  logic        res_taken;
  logic [9:0]  addr;
  logic [9:0]  past;
  logic        upd_valid;
  logic        mispredict;
  logic        stall;
  logic [9:0]  ghr;

  modport master (
    output pc,
    output fetch_br,
    output predict,
    output res_valid,
    output res_taken,
    input  addr,
    input  past,
    input  upd_valid,
    input  mispredict,
    input  stall,
    input  ghr
  );

  modport slave (
    input  pc,
    input  fetch_br,
    input  predict,
    input  res_valid,
    input  res_taken,
    output addr,
    output past,
    output upd_valid,
    output mispredict,
    output stall,
    output ghr
  );
endinterface

// File: rtl/bhr_index_gen.sv
// Global branch history tracker with in-flight queue and misprediction recovery.
// Define GSHARE_XOR_EN for gshare indexing; otherwise bimodal pc[11:2] indexing.
module bhr_index_gen #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  bhr_index_gen_if.slave bif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [9:0] idx;
    logic [9:0] hist;
    logic       pred;
  } ent_t;

  ent_t          q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [9:0]    ghr_spec;
  logic [9:0]    ghr_arch;

  ent_t          hd;
  logic [9:0]    idx;
  logic          full;
  logic          pop;
  logic          flush;
  logic          push;

`ifdef GSHARE_XOR_EN
  assign idx = bif.pc[11:2] ^ ghr_spec;
`else
  assign idx = bif.pc[11:2];
`endif

  always_comb begin
    hd    = q[head];
    full  = (count == FULL);
    pop   = bif.res_valid & (count != '0);
    flush = pop & (bif.res_taken != hd.pred);
    // A flush squashes the younger fetch as well
    push  = bif.fetch_br & ~full & ~flush;
  end

  assign bif.addr       = idx;
  assign bif.past       = hd.idx;
  assign bif.upd_valid  = pop;
  assign bif.mispredict = flush;
  assign bif.stall      = full;
  assign bif.ghr        = ghr_spec;

  always_ff @(posedge clk) begin
    if (push) begin
      q[tail] <= '{idx: idx, hist: ghr_spec, pred: bif.predict};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ghr_spec <= '0;
      ghr_arch <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head     <= head + 1'b1;
        ghr_arch <= {ghr_arch[8:0], bif.res_taken};
      end
      if (flush) begin
        // Rebuild history from the point of the bad prediction
        ghr_spec <= {hd.hist[8:0], bif.res_taken};
        count    <= '0;
        head     <= tail;
      end else begin
        if (push) begin
          ghr_spec <= {ghr_spec[8:0], bif.predict};
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{bif.pc[31:12], bif.pc[1:0],
                       ghr_arch, hd.hist[9]};

endmodule

// File: tb/tb_bhr_index_gen.sv
// Directed bench for bhr_index_gen with DEPTH=4.
// Expected addr values follow the build's indexing mode.
module tb_bhr_index_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bhr_index_gen_if bif ();

  bhr_index_gen #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [9:0] aq [$];

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] xidx(logic [31:0] p,
                                      logic [9:0] g);
`ifdef GSHARE_XOR_EN
    return p[11:2] ^ g;
`else
    return p[11:2] ^ (g & 10'h000);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.fetch_br  = 1'b0;
    bif.predict   = 1'b0;
    bif.res_valid = 1'b0;
    bif.res_taken = 1'b0;
  endtask

  task automatic push(logic [31:0] p, logic pr,
                      logic [9:0] g);
    bif.pc       = p;
    bif.fetch_br = 1'b1;
    bif.predict  = pr;
    #1;
    check("push_ghr", bif.ghr, g);
    check("push_addr", bif.addr, xidx(p, g));
    aq.push_back(xidx(p, g));
    tick();
    idle();
  endtask

  task automatic resolve(logic tk, logic exp_mis);
    bif.res_valid = 1'b1;
    bif.res_taken = tk;
    #1;
    check("res_upd", bif.upd_valid, 1);
    check("res_mis", bif.mispredict, exp_mis);
    check("res_past", bif.past, aq[0]);
    tick();
    void'(aq.pop_front());
    idle();
  endtask

  task automatic empty_res();
    bif.res_valid = 1'b1;
    bif.res_taken = 1'b1;
    #1;
    check("empty_upd", bif.upd_valid, 0);
    check("empty_mis", bif.mispredict, 0);
    tick();
    idle();
  endtask

  logic [31:0] wpc [4];
  logic        wpr [4];
  logic [9:0]  wgh [5];

  initial begin
    wpc[0] = 32'h1000; wpr[0] = 1'b1; wgh[0] = 10'h01A;
    wpc[1] = 32'h1004; wpr[1] = 1'b1; wgh[1] = 10'h035;
    wpc[2] = 32'h2008; wpr[2] = 1'b0; wgh[2] = 10'h06B;
    wpc[3] = 32'h0FFC; wpr[3] = 1'b1; wgh[3] = 10'h0D6;
    wgh[4] = 10'h1AD;

    rst    = 1'b1;
    bif.pc = 32'h0000_0040;
    idle();
    tick();
    rst = 1'b0;
    #1;
    check("rst_ghr", bif.ghr, 0);
    check("rst_stall", bif.stall, 0);
    check("rst_upd", bif.upd_valid, 0);
    check("rst_mis", bif.mispredict, 0);
    check("rst_addr", bif.addr, 10'h010);

    push(32'h100, 1'b1, 10'h000);
    push(32'h204, 1'b0, 10'h001);
    push(32'h3F8, 1'b1, 10'h002);
    check("ghr3", bif.ghr, 10'h005);
    check("nstall3", bif.stall, 0);
    push(32'h040, 1'b1, 10'h005);
    check("ghr4", bif.ghr, 10'h00B);
    check("full_stall", bif.stall, 1);

    // full: fetch ignored while head resolves correctly
    bif.pc        = 32'h500;
    bif.fetch_br  = 1'b1;
    bif.res_valid = 1'b1;
    bif.res_taken = 1'b1;
    #1;
    check("full_stall2", bif.stall, 1);
    check("full_upd", bif.upd_valid, 1);
    check("full_mis", bif.mispredict, 0);
    check("full_past", bif.past, aq[0]);
    tick();
    void'(aq.pop_front());
    idle();
    check("drop_ghr", bif.ghr, 10'h00B);
    check("drop_stall", bif.stall, 0);

    // entry 1 predicted 0 with ghr 0x001; taken -> recover
    bif.pc        = 32'h600;
    bif.fetch_br  = 1'b1;
    bif.res_valid = 1'b1;
    bif.res_taken = 1'b1;
    #1;
    check("mis1", bif.mispredict, 1);
    check("mis1_past", bif.past, aq[0]);
    tick();
    idle();
    aq.delete();
    check("rec1_ghr", bif.ghr, 10'h003);
    check("rec1_stall", bif.stall, 0);
    empty_res();
    check("empty_ghr", bif.ghr, 10'h003);

    push(32'h7FC, 1'b1, 10'h003);
    check("ghr7", bif.ghr, 10'h007);
    bif.pc        = 32'h010;
    bif.fetch_br  = 1'b1;
    bif.predict   = 1'b1;
    bif.res_valid = 1'b1;
    bif.res_taken = 1'b0;
    #1;
    check("mis2", bif.mispredict, 1);
    check("mis2_past", bif.past, aq[0]);
    tick();
    idle();
    aq.delete();
    check("rec2_ghr", bif.ghr, 10'h006);
    empty_res();

    // push and correct pop together
    push(32'h0C0, 1'b1, 10'h006);
    bif.pc        = 32'h0C4;
    bif.fetch_br  = 1'b1;
    bif.predict   = 1'b0;
    bif.res_valid = 1'b1;
    bif.res_taken = 1'b1;
    #1;
    check("pp_addr", bif.addr, xidx(32'h0C4, 10'h00D));
    check("pp_mis", bif.mispredict, 0);
    check("pp_past", bif.past, aq[0]);
    tick();
    void'(aq.pop_front());
    aq.push_back(xidx(32'h0C4, 10'h00D));
    idle();
    check("pp_ghr", bif.ghr, 10'h01A);
    resolve(1'b0, 1'b0);
    check("pp_ghr2", bif.ghr, 10'h01A);
    empty_res();

    // pointers now sit mid-queue: fill and drain to wrap
    for (int i = 0; i < 4; i++) push(wpc[i], wpr[i], wgh[i]);
    check("wrap_stall", bif.stall, 1);
    check("wrap_ghr", bif.ghr, wgh[4]);
    for (int i = 0; i < 4; i++) resolve(wpr[i], 1'b0);
    check("wrap_nstall", bif.stall, 0);
    check("wrap_ghr2", bif.ghr, wgh[4]);
    empty_res();

    // reset wins over push and pop
    push(32'h040, 1'b1, 10'h1AD);
    check("pre_rst_ghr", bif.ghr, 10'h35B);
    rst           = 1'b1;
    bif.fetch_br  = 1'b1;
    bif.predict   = 1'b1;
    bif.res_valid = 1'b1;
    bif.res_taken = 1'b0;
    tick();
    rst = 1'b0;
    idle();
    aq.delete();
    bif.pc = 32'h0000_0040;
    #1;
    check("rst2_ghr", bif.ghr, 0);
    check("rst2_stall", bif.stall, 0);
    check("rst2_addr", bif.addr, 10'h010);
    empty_res();

    // saturate history with taken predictions
    push(32'h040, 1'b1, 10'h000);
    for (int i = 0; i < 9; i++) begin
      bif.pc        = 32'h040;
      bif.fetch_br  = 1'b1;
      bif.predict   = 1'b1;
      bif.res_valid = 1'b1;
      bif.res_taken = 1'b1;
      #1;
      check("sat_mis", bif.mispredict, 0);
      check("sat_past", bif.past, aq[0]);
      aq.push_back(bif.addr);
      tick();
      void'(aq.pop_front());
      idle();
    end
    check("sat_ghr", bif.ghr, 10'h3FF);
    bif.pc = 32'h0000_0040;
    #1;
`ifdef GSHARE_XOR_EN
    check("sat_addr", bif.addr, 10'h3EF);
`else
    check("sat_addr", bif.addr, 10'h010);
`endif
    resolve(1'b1, 1'b0);
    empty_res();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bhr_index_gen.md
BHR_INDEX_GEN -- requirements
Module: bhr_index_gen

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight branch queue entries (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port pc  input  32  fetch PC of the current instruction.
REQ-005 SHALL have port fetch_br  input  1  current fetch is a conditional branch (opcode 1100011), valid this cycle.
REQ-006 SHALL have port predict  input  1  prediction returned by the pattern table for addr.
REQ-007 SHALL have port res_valid  input  1  oldest in-flight branch resolves this cycle.
REQ-008 SHALL have port res_taken  input  1  actual outcome of the resolving branch.
REQ-009 SHALL have port addr  output  10  pattern-table lookup index.
REQ-010 SHALL have port past  output  10  pattern-table update index (index used at prediction of the resolving branch).
REQ-011 SHALL have port upd_valid  output  1  past/res_taken are valid for a table update.
REQ-012 SHALL have port mispredict  output  1  resolving branch outcome differs from its stored prediction.
REQ-013 SHALL have port stall  output  1  queue full; fetch must hold.
REQ-014 SHALL have port ghr  output  10  current speculative global history.

Function
REQ-015 SHALL hold speculative history ghr_spec[9:0] and architectural history ghr_arch[9:0].
REQ-016 SHALL drive addr combinationally as pc[11:2] XOR ghr_spec when GSHARE_XOR_EN is defined, else pc[11:2].
REQ-017 SHALL, on push (fetch_br & !stall & !flush), write entry {addr, ghr_spec, predict} at tail and set ghr_spec <= {ghr_spec[8:0], predict} next edge.
REQ-018 SHALL drive stall = (count == DEPTH), combinational; push while full is ignored, no history change, even if a pop occurs the same cycle.
REQ-019 SHALL drive past = head entry index combinationally; upd_valid = res_valid & (count != 0); mispredict = upd_valid & (res_taken != head predict bit).
REQ-020 SHALL, on pop (upd_valid), advance head, decrement count, and set ghr_arch <= {ghr_arch[8:0], res_taken}.
REQ-021 SHALL treat res_valid with empty queue as a no-op (upd_valid=0, mispredict=0, no state change).
REQ-022 SHALL, on pop with mispredict, set ghr_spec <= {head_ghr[8:0], res_taken}, clear count to 0, set head=tail, and discard any same-cycle push (flush).
REQ-023 SHALL, on simultaneous push and correct pop, perform both: count unchanged, ghr_spec shifted by predict.
REQ-024 SHALL wrap head/tail pointers modulo DEPTH without loss of entries.
REQ-025 SHALL have zero-cycle latency from res_valid to past/upd_valid/mispredict and one-cycle latency to history updates.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, clear ghr_spec, ghr_arch, count, head, tail to 0; outputs then: ghr=0, stall=0, upd_valid=0, mispredict=0, addr=pc[11:2].
REQ-027 SHALL give rst priority over simultaneous push/pop; in-flight entries are discarded.

Configuration
REQ-028 SHALL, with GSHARE_XOR_EN defined, use gshare indexing (REQ-016 XOR form); without it, bimodal indexing pc[11:2] with history still tracked, queued and recovered identically.

Verification
REQ-029 Reset, pc=0x0000_0040, GSHARE_XOR_EN on -> addr=0x010, ghr=0, stall=0.
REQ-030 Push 3 branches with predict=1,0,1 from ghr=0 -> ghr=0x005; entries hold ghr 0x000,0x001,0x002.
REQ-031 Fill DEPTH=4 entries -> stall=1; 5th fetch_br with res_valid same cycle -> push ignored, count=3 next cycle.
REQ-032 Head predicted 1 with ghr 0x003, res_taken=0 -> mispredict=1, next ghr=0x006, count=0, same-cycle push dropped.
REQ-033 res_valid=1 with empty queue -> upd_valid=0, mispredict=0, ghr unchanged.
REQ-034 GSHARE_XOR_EN undefined, ghr=0x3FF, pc=0x0000_0040 -> addr=0x010.
